bubble_mem_arbiter: RTL and testbench
=====================================

// Module: bubble_mem_arbiter
// PURPOSE
//  Shares the single-port veda_mem between instruction fetch (IF) and data load/store (D) of the BUBBLE core.
//  Fixed priority to D, with an anti-starvation override for IF. One transaction in flight at a time.
//  Returns read data after the memory latency. Sits between the core sequencer and the memory array.
// PARAMETERS
//  ADDR_W      10  word-address width (1024-word memory)
//  DATA_W      32  data word width
//  MEM_LAT     1   memory read latency in cycles (>=1); mem_rdata valid MEM_LAT cycles after mem_en
//  STARVE_LIM  4   consecutive cycles IF may be denied while requesting before it wins (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous active-low reset
//  if_req     in   1       IF read request; if_addr held stable while if_req=1 and if_gnt=0
//  if_addr    in   ADDR_W  IF word address
//  if_gnt     out  1       1-cycle pulse: IF request accepted and issued to memory this cycle
//  if_rvalid  out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  read data (mem_rdata, qualified by if_rvalid)
//  d_req      in   1       data request; d_we/d_addr/d_wdata held stable until d_gnt
//  d_we       in   1       1=store word, 0=load word
//  d_addr     in   ADDR_W  data word address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       1-cycle pulse: data request issued this cycle
//  d_rvalid   out  1       1-cycle pulse: d_rdata valid (loads only)
//  d_rdata    out  DATA_W  read data (mem_rdata, qualified by d_rvalid)
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable (valid with mem_en)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 while a read is outstanding
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; all gnt/rvalid/mem_en/mem_we/busy = 0; starve counter 0; outstanding read discarded (no rvalid ever).
//  - States: IDLE (may grant), RD_WAIT (read in flight, latency counter running).
//  - Grant rule in IDLE, same cycle as request seen (combinational grant, 0-cycle latency):
//    both req: D wins unless starve_cnt==STARVE_LIM, then IF wins; single req: that requester wins.
//  - Grant cycle: gnt pulse, mem_en=1, mem_addr/mem_we/mem_wdata from winner (IF: mem_we=0, mem_wdata=0).
//  - Write grant: stay IDLE; next grant possible next cycle; no rvalid.
//  - Read grant at cycle T: -> RD_WAIT, busy=1, owner latched; rvalid of owner at T+MEM_LAT, rdata=mem_rdata that cycle.
//  - rvalid cycle returns to IDLE arbitration: a new grant may issue in the same cycle as rvalid (back-to-back reads every MEM_LAT cycles).
//  - In RD_WAIT no gnt, mem_en=0; requests wait.
//  - starve_cnt: +1 each cycle if_req=1 and if_gnt=0 (incl. RD_WAIT); saturates at STARVE_LIM; cleared on if_gnt.
//  - Withdrawn request (req falls before gnt): legal, no grant, no side effects.
//  - gnt and rvalid never asserted on both ports in the same cycle for gnt; at most one rvalid per cycle.
//  - Address arithmetic unsigned, ADDR_W bits, no wrap checks (full range legal).
//  - When neither port holds rvalid, the rdata outputs are don't-care.
// STRUCTURE
//  - Package bubble_mem_pkg: state enum {IDLE, RD_WAIT}; port id constants PORT_IF=0, PORT_D=1; default widths.
//  - Sub-module bubble_rsp_tracker: latency down-counter + latched owner id, emits one-hot rvalid at T+MEM_LAT.
//  - Top holds arbitration logic, starve counter, memory mux.
// TESTING (MEM_LAT=1, STARVE_LIM=4 unless noted; behavioural memory model)
//  1 reset: rst_n=0 2 cycles with both req=1 -> all gnt/rvalid/mem_en=0; after release D granted first.
//  2 single IF read addr 5 (mem[5]=0xDEADBEEF) -> if_gnt cycle T, if_rvalid and if_rdata=0xDEADBEEF at T+1.
//  3 both req continuous, D=loads -> D granted 4 times, 5th grant to IF, starve_cnt back to 0 then D again.
//  4 D store addr 12 data 0x12345678 then D load addr 12 -> d_gnt on consecutive cycles, d_rvalid with 0x12345678 one cycle after load grant.
//  5 MEM_LAT=3, IF read granted at T, D req at T+1 -> no gnt T+1..T+2, if_rvalid T+3, d_gnt T+3.
//  6 rst_n=0 at T+1 during MEM_LAT=3 read -> no if_rvalid ever, busy=0 after reset, fresh grant post-reset.

Source files
------------

// File: rtl/bubble_mem_pkg.sv
// Shared types and constants for the BUBBLE memory arbiter slice.
// Holds the arbiter state encoding, requester ids and default widths.
package bubble_mem_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_LIM = 4;

endpackage

// File: rtl/bubble_rsp_tracker.sv
// Tracks the single outstanding read: latency down-counter plus latched owner,
// producing a one-hot read-valid pulse MEM_LAT cycles after issue.
module bubble_rsp_tracker
    import bubble_mem_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic issue_owner,
    output logic rsp_last,
    output logic if_rvalid,
    output logic d_rvalid
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             owner;

    // A new issue in the final cycle reloads the counter, giving back-to-back reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= LAT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            owner <= issue_owner;
        end
    end

    always_comb begin
        rsp_last  = rst_n && (cnt == CNT_ONE);
        if_rvalid = rsp_last && (owner == PORT_IF);
        d_rvalid  = rsp_last && (owner == PORT_D);
    end

endmodule

// File: rtl/bubble_mem_arbiter.sv
// Shares the single-port memory between instruction fetch and data access:
// data has priority, fetch wins once it has been starved STARVE_LIM cycles.
module bubble_mem_arbiter
    import bubble_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int STARVE_W = $clog2(STARVE_LIM + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    arb_state_e          state;
    arb_state_e          state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                rsp_last;
    logic                can_grant;
    logic                issue_rd;
    logic                issue_owner;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue_rd) state_nxt = RD_WAIT;
            RD_WAIT: if (rsp_last && !issue_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The final cycle of an outstanding read may already arbitrate the next access.
    always_comb begin
        can_grant = rst_n && ((state == IDLE) || rsp_last);
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if (can_grant) begin
            if (if_req && d_req) begin
                if (starve_cnt == STARVE_MAX) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
        busy        = (state == RD_WAIT);
        mem_en      = if_gnt || d_gnt;
        mem_we      = d_gnt && d_we;
        mem_addr    = d_gnt ? d_addr : if_addr;
        mem_wdata   = d_gnt ? d_wdata : '0;
        issue_rd    = if_gnt || (d_gnt && !d_we);
        issue_owner = d_gnt ? PORT_D : PORT_IF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (if_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    bubble_rsp_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_rsp_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue_rd),
        .issue_owner (issue_owner),
        .rsp_last    (rsp_last),
        .if_rvalid   (if_rvalid),
        .d_rvalid    (d_rvalid)
    );

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_bubble_mem_arbiter.sv
// Bench for bubble_mem_arbiter: vector table and corner sequences plus
// randomized traffic against a transaction-level reference model.
module tb_bubble_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LAT_A = 1;
    localparam int LIM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst_n, a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [AW-1:0] a_if_addr, a_d_addr, a_mem_addr;
    logic [DW-1:0] a_if_rdata, a_d_wdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic          a_mem_en, a_mem_we, a_busy;
    logic          b_rst_n, b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [AW-1:0] b_if_addr, b_d_addr, b_mem_addr;
    logic [DW-1:0] b_if_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic          b_mem_en, b_mem_we, b_busy;

    bubble_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .STARVE_LIM(LIM)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    bubble_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_LIM(LIM)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] init_word(input int a);
        if (a == 5) return 32'hDEADBEEF;
        if (a == 9) return 32'hCAFE0009;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural memories: one-cycle latency for A, three-cycle for B.
    logic          mem_init;
    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] mem_b [1024];
    logic [AW-1:0] a_pipe, b_pipe0, b_pipe1, b_pipe2;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        end
        a_pipe  <= a_mem_addr;
        b_pipe0 <= b_mem_addr;
        b_pipe1 <= b_pipe0;
        b_pipe2 <= b_pipe1;
    end

    assign a_mem_rdata = mem_a[a_pipe];
    assign b_mem_rdata = mem_b[b_pipe2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst_n;
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          e_if_gnt;
        logic          e_d_gnt;
        logic          e_if_rv;
        logic          e_d_rv;
        logic          e_busy;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic i_req, input logic [AW-1:0] i_addr,
                                input logic d_req, input logic d_we, input logic [AW-1:0] d_addr,
                                input logic [DW-1:0] d_wd, input logic eig, input logic edg,
                                input logic eirv, input logic edrv, input logic ebusy,
                                input logic [DW-1:0] erd);
        vec_t v;
        v.rst_n = rst_n;  v.if_req = i_req; v.if_addr = i_addr;
        v.d_req = d_req;  v.d_we = d_we;    v.d_addr = d_addr; v.d_wdata = d_wd;
        v.e_if_gnt = eig; v.e_d_gnt = edg;  v.e_if_rv = eirv;  v.e_d_rv = edrv;
        v.e_busy = ebusy; v.e_rdata = erd;
        return v;
    endfunction

    task automatic b_set(input logic i_req, input logic dr);
        b_if_req = i_req; b_if_addr = 10'd9;
        b_d_req = dr; b_d_we = 1'b0; b_d_addr = 10'd20; b_d_wdata = '0;
    endtask

    task automatic b_exp(input string tag, input logic ig, input logic dg, input logic irv,
                         input logic drv, input logic chk_busy, input logic ebusy);
        @(negedge clk);
        chk1({tag, "_if_gnt"}, b_if_gnt, ig);
        chk1({tag, "_d_gnt"}, b_d_gnt, dg);
        chk1({tag, "_if_rvalid"}, b_if_rvalid, irv);
        chk1({tag, "_d_rvalid"}, b_d_rvalid, drv);
        if (irv) chk32({tag, "_if_rdata"}, b_if_rdata, init_word(9));
        if (drv) chk32({tag, "_d_rdata"}, b_d_rdata, init_word(20));
        if (chk_busy) chk1({tag, "_busy"}, b_busy, ebusy);
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] w7;
    int            cyc, m_due, m_starve;
    bit            m_busy, m_owner_d, rsp_now, free, e_ig, e_dg, if_pend, d_pend;
    logic [DW-1:0] m_data;

    initial begin
        a_rst_n = 1'b0; a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_d_addr = '0; a_d_wdata = '0;
        b_rst_n = 1'b0; b_set(1'b0, 1'b0);
        mem_init = 1'b0;
        @(posedge clk); #1;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;

        w7 = init_word(7);
        //                 rst  ireq iaddr  dreq dwe daddr   dwdata        ig dg irv drv busy rdata
        vecs.push_back(mk(1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, w7));
        vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, w7));
        vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, w7));
        vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w7));
        vecs.push_back(mk(1'b1, 1'b0, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b0, 10'd5, 1'b0, 1'b0, 10'd7, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w7));
        vecs.push_back(mk(1'b1, 1'b0, 10'd5, 1'b0, 1'b0, 10'd7, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b0, 1'b0, 10'd7, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 10'd5, 1'b0, 1'b0, 10'd7, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 10'd12, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd12, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd12, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678));
        vecs.push_back(mk(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd12, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

        foreach (vecs[i]) begin
            a_rst_n = vecs[i].rst_n; a_if_req = vecs[i].if_req; a_if_addr = vecs[i].if_addr;
            a_d_req = vecs[i].d_req; a_d_we = vecs[i].d_we; a_d_addr = vecs[i].d_addr;
            a_d_wdata = vecs[i].d_wdata;
            @(negedge clk);
            chk1($sformatf("v%0d_if_gnt", i), a_if_gnt, vecs[i].e_if_gnt);
            chk1($sformatf("v%0d_d_gnt", i), a_d_gnt, vecs[i].e_d_gnt);
            chk1($sformatf("v%0d_if_rvalid", i), a_if_rvalid, vecs[i].e_if_rv);
            chk1($sformatf("v%0d_d_rvalid", i), a_d_rvalid, vecs[i].e_d_rv);
            chk1($sformatf("v%0d_mem_en", i), a_mem_en, vecs[i].e_if_gnt | vecs[i].e_d_gnt);
            chk1($sformatf("v%0d_busy", i), a_busy, vecs[i].e_busy);
            if (vecs[i].e_if_rv) chk32($sformatf("v%0d_if_rdata", i), a_if_rdata, vecs[i].e_rdata);
            if (vecs[i].e_d_rv) chk32($sformatf("v%0d_d_rdata", i), a_d_rdata, vecs[i].e_rdata);
            @(posedge clk); #1;
        end
        a_if_req = 1'b0; a_d_req = 1'b0;

        // Three-cycle latency: requests wait out the read, then grant on the rvalid cycle.
        b_rst_n = 1'b1;
        b_set(1'b0, 1'b0); b_exp("b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_set(1'b1, 1'b0); b_exp("t5_T0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_set(1'b0, 1'b1); b_exp("t5_T1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        b_exp("t5_T2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        b_exp("t5_T3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        b_set(1'b0, 1'b0); b_exp("t5_T4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        b_exp("t5_T5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        b_exp("t5_T6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        b_exp("t5_T7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during an outstanding read discards it.
        b_set(1'b1, 1'b0); b_exp("t6_T0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_set(1'b0, 1'b0); b_rst_n = 1'b0;
        b_exp("t6_T1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b_rst_n = 1'b1;
        b_exp("t6_T2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_exp("t6_T3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_exp("t6_T4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_set(1'b0, 1'b1); b_exp("t6_T5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        b_set(1'b0, 1'b0); b_exp("t6_T6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        b_exp("t6_T7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        b_exp("t6_T8", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        b_exp("t6_T9", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic on A against a transaction-level model.
        a_rst_n = 1'b0; mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        cyc = 0; m_busy = 1'b0; m_due = 0; m_starve = 0; m_owner_d = 1'b0; m_data = '0;
        if_pend = 1'b0; d_pend = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if (!if_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    if_pend = 1'b1;
                    a_if_addr = 10'($urandom_range(0, 63));
                end
            end else if ($urandom_range(0, 9) == 0) begin
                if_pend = 1'b0;
            end
            if (!d_pend) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_pend = 1'b1;
                    a_d_we = ($urandom_range(0, 2) == 0);
                    a_d_addr = 10'($urandom_range(0, 63));
                    a_d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                d_pend = 1'b0;
            end
            a_if_req = if_pend;
            a_d_req = d_pend;

            rsp_now = m_busy && (m_due == cyc);
            free = !m_busy || rsp_now;
            e_ig = 1'b0; e_dg = 1'b0;
            if (free) begin
                if (if_pend && d_pend) begin
                    if (m_starve == LIM) e_ig = 1'b1;
                    else e_dg = 1'b1;
                end else if (if_pend) begin
                    e_ig = 1'b1;
                end else if (d_pend) begin
                    e_dg = 1'b1;
                end
            end

            @(negedge clk);
            chk1("rnd_if_gnt", a_if_gnt, e_ig);
            chk1("rnd_d_gnt", a_d_gnt, e_dg);
            chk1("rnd_if_rvalid", a_if_rvalid, rsp_now && !m_owner_d);
            chk1("rnd_d_rvalid", a_d_rvalid, rsp_now && m_owner_d);
            chk1("rnd_busy", a_busy, m_busy);
            chk1("rnd_mem_en", a_mem_en, e_ig || e_dg);
            if (rsp_now && !m_owner_d) chk32("rnd_if_rdata", a_if_rdata, m_data);
            if (rsp_now && m_owner_d) chk32("rnd_d_rdata", a_d_rdata, m_data);
            if (e_ig) begin
                chk32("rnd_mem_addr_if", 32'(a_mem_addr), 32'(a_if_addr));
                chk1("rnd_mem_we_if", a_mem_we, 1'b0);
            end
            if (e_dg) begin
                chk32("rnd_mem_addr_d", 32'(a_mem_addr), 32'(a_d_addr));
                chk1("rnd_mem_we_d", a_mem_we, a_d_we);
                if (a_d_we) chk32("rnd_mem_wdata", a_mem_wdata, a_d_wdata);
            end
            @(posedge clk); #1;

            if (rsp_now) m_busy = 1'b0;
            if (e_ig) begin
                m_busy = 1'b1; m_due = cyc + LAT_A; m_owner_d = 1'b0;
                m_data = ref_mem[a_if_addr];
                if_pend = 1'b0; m_starve = 0;
            end else if (if_pend) begin
                m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
            end
            if (e_dg) begin
                if (a_d_we) begin
                    ref_mem[a_d_addr] = a_d_wdata;
                end else begin
                    m_busy = 1'b1; m_due = cyc + LAT_A; m_owner_d = 1'b1;
                    m_data = ref_mem[a_d_addr];
                end
                d_pend = 1'b0;
            end
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
